// File: rtl/grid_pixel_gen.sv
// Cell-grid pixel generator: a 2-stage pipeline that composes mouse sprite,
// edit cursor (with frame-based blink), grid lines and glyph pixels into one colour.
module grid_pixel_gen #(
  parameter int CELL_LOG2    = 5,
  parameter int H_W          = 10,
  parameter int V_W          = 9,
  parameter int CW           = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic                   frame_start,
  input  logic [H_W-1:0]         h_cnt,
  input  logic [V_W-1:0]         v_cnt,
  input  logic                   mouse_en,
  input  logic [CW-1:0]          mouse_pixel,
  input  logic                   word_en,
  input  logic                   word_pixel,
  input  logic                   canvas_pixel,
  input  logic                   editing,
  input  logic [H_W-CELL_LOG2-1:0] edit_x,
  input  logic [V_W-CELL_LOG2-1:0] edit_y,
  input  logic [H_W-1:0]         mouse_x,
  input  logic [V_W-1:0]         mouse_y,
  input  logic [CW-1:0]          grid_color,
  input  logic [CW-1:0]          cursor_color,
  input  logic [CW-1:0]          fg_color,
  output logic [CW-1:0]          pixel_color,
  output logic                   pixel_valid
);

  localparam int XW = H_W - CELL_LOG2;
  localparam int YW = V_W - CELL_LOG2;
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  function automatic logic is_edge(input logic [CELL_LOG2-1:0] low);
    return (low == {CELL_LOG2{1'b0}}) || (low == {CELL_LOG2{1'b1}});
  endfunction

  logic            vld_p0, mouse_en_p0, word_en_p0, word_pixel_p0, canvas_p0, editing_p0;
  logic [H_W-1:0]  h_p0;
  logic [V_W-1:0]  v_p0;
  logic [XW-1:0]   edit_x_p0, mouse_cx_p0;
  logic [YW-1:0]   edit_y_p0, mouse_cy_p0;
  logic [CW-1:0]   mouse_pixel_p0, grid_p0, cursor_p0, fg_p0;

  logic [7:0]      frame_cnt;
  logic            blink_on;
  logic            restart;
  logic            border, edit_cell, hover;
  logic [CW-1:0]   color_nxt;

  // Only the cell index of the mouse position matters; its sub-cell bits are dropped.
  logic unused_mouse_low;
  assign unused_mouse_low = ^{mouse_x[CELL_LOG2-1:0], mouse_y[CELL_LOG2-1:0]};

  // Stage 1: capture one coherent sample of every pixel-path input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0         <= 1'b0;
      mouse_en_p0    <= 1'b0;
      word_en_p0     <= 1'b0;
      word_pixel_p0  <= 1'b0;
      canvas_p0      <= 1'b0;
      editing_p0     <= 1'b0;
      h_p0           <= '0;
      v_p0           <= '0;
      edit_x_p0      <= '0;
      edit_y_p0      <= '0;
      mouse_cx_p0    <= '0;
      mouse_cy_p0    <= '0;
      mouse_pixel_p0 <= '0;
      grid_p0        <= '0;
      cursor_p0      <= '0;
      fg_p0          <= '0;
    end else begin
      vld_p0         <= valid;
      mouse_en_p0    <= mouse_en;
      word_en_p0     <= word_en;
      word_pixel_p0  <= word_pixel;
      canvas_p0      <= canvas_pixel;
      editing_p0     <= editing;
      h_p0           <= h_cnt;
      v_p0           <= v_cnt;
      edit_x_p0      <= edit_x;
      edit_y_p0      <= edit_y;
      mouse_cx_p0    <= mouse_x[H_W-1:CELL_LOG2];
      mouse_cy_p0    <= mouse_y[V_W-1:CELL_LOG2];
      mouse_pixel_p0 <= mouse_pixel;
      grid_p0        <= grid_color;
      cursor_p0      <= cursor_color;
      fg_p0          <= fg_color;
    end
  end

  // Moving the cursor or entering edit mode restarts the blink in its visible phase.
  assign restart = (edit_x != edit_x_p0) || (edit_y != edit_y_p0) || (editing && !editing_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
      blink_on  <= 1'b1;
    end else if (restart) begin
      frame_cnt <= 8'd0;
      blink_on  <= 1'b1;
    end else if (editing && frame_start) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= 8'd0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    border    = is_edge(h_p0[CELL_LOG2-1:0]) || is_edge(v_p0[CELL_LOG2-1:0]);
    edit_cell = (h_p0[H_W-1:CELL_LOG2] == edit_x_p0) && (v_p0[V_W-1:CELL_LOG2] == edit_y_p0);
    hover     = (h_p0[H_W-1:CELL_LOG2] == mouse_cx_p0) && (v_p0[V_W-1:CELL_LOG2] == mouse_cy_p0);
    color_nxt = '0;
    if (!vld_p0) begin
      color_nxt = '0;
    end else if (mouse_en_p0) begin
      color_nxt = mouse_pixel_p0;
    end else if (editing_p0 && edit_cell) begin
      if (border) color_nxt = blink_on ? cursor_p0 : grid_p0;
      else        color_nxt = canvas_p0 ? fg_p0 : '0;
    end else if (border) begin
      color_nxt = (!editing_p0 && hover) ? cursor_p0 : grid_p0;
    end else if (word_en_p0 && word_pixel_p0) begin
      color_nxt = fg_p0;
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_color <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_color <= color_nxt;
      pixel_valid <= vld_p0;
    end
  end

endmodule
